cdb_broadcast: RTL and testbench

CDB_BROADCAST -- requirements
Module: cdb_broadcast

---
 rtl/cdb_broadcast_pkg.sv | 42 ++++
 rtl/cdb_buffer.sv | 54 +++++
 rtl/cdb_broadcast.sv | 142 ++++++++++++++
 tb/tb_cdb_broadcast.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_broadcast_pkg.sv
// Shared types and widths for the CDB broadcast block and the ROB that consumes it.
// Machine sizes come from `WAYS, `ROB, `PRF and `XLEN; the defaults below apply when the build does not set them.
`ifndef WAYS
`define WAYS 3
`endif
`ifndef ROB
`define ROB 32
`endif
`ifndef PRF
`define PRF 64
`endif
`ifndef XLEN
`define XLEN 32
`endif

package cdb_broadcast_pkg;

   localparam int unsigned WAYS  = `WAYS;
   localparam int unsigned ROB_W = $clog2(`ROB);
   localparam int unsigned PRF_W = $clog2(`PRF);
   localparam int unsigned XLEN  = `XLEN;

   // One completed result as carried on a CDB lane
   typedef struct packed {
      logic [ROB_W-1:0] ROB_idx;
      logic [PRF_W-1:0] dest_PRN;
      logic [XLEN-1:0]  value;
      logic             direction;
      logic [XLEN-1:0]  target;
   } cdb_packet_t;

   // Reorder-buffer entry as updated by CDB broadcasts
   typedef struct packed {
      logic             valid;
      logic             complete;
      logic [PRF_W-1:0] dest_PRN;
      logic [PRF_W-1:0] prev_PRN;
      logic             direction;
      logic [XLEN-1:0]  target;
   } rob_entry_t;

endpackage

// File: rtl/cdb_buffer.sv
// Circular result FIFO for the CDB: up to NUM_FU pushes and WAYS pops per cycle.
// The WAYS oldest entries are presented combinationally for the broadcast registers.
module cdb_buffer
   import cdb_broadcast_pkg::*;
#(
   parameter int unsigned NUM_FU    = 4,
   parameter int unsigned BUF_DEPTH = 8
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          flush,
   input  logic [$clog2(NUM_FU+1)-1:0]   push_cnt,
   input  cdb_packet_t                   push_data [NUM_FU],
   input  logic [$clog2(WAYS+1)-1:0]     pop_cnt,
   output logic [$clog2(BUF_DEPTH):0]    count,
   output cdb_packet_t                   head_data [WAYS]
);

   localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   cdb_packet_t      mem [BUF_DEPTH];

   // Pointers wrap naturally because BUF_DEPTH is a power of two
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PTR_W'(pop_cnt);
         tail  <= tail + PTR_W'(push_cnt);
         count <= count + CNT_W'(push_cnt) - CNT_W'(pop_cnt);
      end
   end

   // Storage carries no reset; occupancy is tracked entirely by head/tail/count
   always_ff @(posedge clock) begin
      for (int i = 0; i < int'(NUM_FU); i++) begin
         if (i < int'(push_cnt)) mem[tail + PTR_W'(i)] <= push_data[i];
      end
   end

   always_comb begin
      for (int j = 0; j < int'(WAYS); j++) head_data[j] = mem[head + PTR_W'(j)];
   end

endmodule

// File: rtl/cdb_broadcast.sv
// Common data bus broadcaster: collects FU results, buffers them and drives up to WAYS registered lanes per cycle.
// Optional same-edge bypass of the buffer into spare lanes is enabled by defining CDB_BYPASS_EN.
module cdb_broadcast
   import cdb_broadcast_pkg::*;
#(
   parameter int unsigned NUM_FU    = 4,
   parameter int unsigned BUF_DEPTH = 8
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                proc_nuke,
   input  logic [NUM_FU-1:0]   fu_valid,
   output logic [NUM_FU-1:0]   fu_ready,
   input  logic [ROB_W-1:0]    fu_ROB_idx   [NUM_FU],
   input  logic [PRF_W-1:0]    fu_dest_PRN  [NUM_FU],
   input  logic [XLEN-1:0]     fu_value     [NUM_FU],
   input  logic [NUM_FU-1:0]   fu_direction,
   input  logic [XLEN-1:0]     fu_target    [NUM_FU],
   output logic [WAYS-1:0]     CDB_valid,
   output logic [ROB_W-1:0]    CDB_ROB_idx  [WAYS],
   output logic [PRF_W-1:0]    CDB_dest_PRN [WAYS],
   output logic [XLEN-1:0]     CDB_value    [WAYS],
   output logic [WAYS-1:0]     CDB_direction,
   output logic [XLEN-1:0]     CDB_target   [WAYS]
);

   localparam int unsigned CNT_W  = $clog2(BUF_DEPTH) + 1;
   localparam int unsigned PUSH_W = $clog2(NUM_FU + 1);
   localparam int unsigned POP_W  = $clog2(WAYS + 1);

   logic [CNT_W-1:0]  count;
   logic [NUM_FU-1:0] acc;
   logic [PUSH_W-1:0] push_cnt;
   logic [POP_W-1:0]  pop_cnt;
   logic [WAYS-1:0]   lane_valid;
   cdb_packet_t       fu_pkt     [NUM_FU];
   cdb_packet_t       push_data  [NUM_FU];
   cdb_packet_t       head_data  [WAYS];
   cdb_packet_t       lane_pkt   [WAYS];
   cdb_packet_t       cdb_q      [WAYS];
   int                rank       [NUM_FU];
   int                n_acc;
   int                pop_k;
   int                free_lanes;
   int                byp;

   // Readiness depends on registered occupancy only
   always_comb begin
      fu_ready = '0;
      for (int i = 0; i < int'(NUM_FU); i++) fu_ready[i] = (int'(BUF_DEPTH) - int'(count)) > i;
   end

   // Rank accepted results in FU order, then split them between spare lanes and the buffer
   always_comb begin
      acc   = '0;
      n_acc = 0;
      for (int i = 0; i < int'(NUM_FU); i++) begin
         fu_pkt[i].ROB_idx   = fu_ROB_idx[i];
         fu_pkt[i].dest_PRN  = fu_dest_PRN[i];
         fu_pkt[i].value     = fu_value[i];
         fu_pkt[i].direction = fu_direction[i];
         fu_pkt[i].target    = fu_target[i];
         rank[i]             = n_acc;
         acc[i]              = fu_valid[i] & fu_ready[i];
         if (acc[i]) n_acc = n_acc + 1;
      end

      pop_k = (int'(count) < int'(WAYS)) ? int'(count) : int'(WAYS);
`ifdef CDB_BYPASS_EN
      free_lanes = int'(WAYS) - pop_k;
`else
      free_lanes = 0;
`endif
      byp      = (n_acc < free_lanes) ? n_acc : free_lanes;
      push_cnt = PUSH_W'(n_acc - byp);
      pop_cnt  = POP_W'(pop_k);

      for (int s = 0; s < int'(NUM_FU); s++) begin
         push_data[s] = '0;
         for (int i = 0; i < int'(NUM_FU); i++) begin
            if (acc[i] && rank[i] == s + byp) push_data[s] = fu_pkt[i];
         end
      end

      for (int j = 0; j < int'(WAYS); j++) begin
         lane_valid[j] = 1'b0;
         lane_pkt[j]   = '0;
         if (j < pop_k) begin
            lane_valid[j] = 1'b1;
            lane_pkt[j]   = head_data[j];
         end
`ifdef CDB_BYPASS_EN
         for (int i = 0; i < int'(NUM_FU); i++) begin
            if (acc[i] && rank[i] < byp && pop_k + rank[i] == j) begin
               lane_valid[j] = 1'b1;
               lane_pkt[j]   = fu_pkt[i];
            end
         end
`endif
      end
   end

   cdb_buffer #(
      .NUM_FU    (NUM_FU),
      .BUF_DEPTH (BUF_DEPTH)
   ) u_buffer (
      .clock     (clock),
      .reset_n   (reset_n),
      .flush     (proc_nuke),
      .push_cnt  (push_cnt),
      .push_data (push_data),
      .pop_cnt   (pop_cnt),
      .count     (count),
      .head_data (head_data)
   );

   // Broadcast lanes; a flush also kills whatever would have been loaded at that edge
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         CDB_valid <= '0;
         for (int j = 0; j < int'(WAYS); j++) cdb_q[j] <= '0;
      end else if (proc_nuke) begin
         CDB_valid <= '0;
         for (int j = 0; j < int'(WAYS); j++) cdb_q[j] <= '0;
      end else begin
         CDB_valid <= lane_valid;
         for (int j = 0; j < int'(WAYS); j++) cdb_q[j] <= lane_pkt[j];
      end
   end

   always_comb begin
      CDB_direction = '0;
      for (int j = 0; j < int'(WAYS); j++) begin
         CDB_ROB_idx[j]   = cdb_q[j].ROB_idx;
         CDB_dest_PRN[j]  = cdb_q[j].dest_PRN;
         CDB_value[j]     = cdb_q[j].value;
         CDB_direction[j] = cdb_q[j].direction;
         CDB_target[j]    = cdb_q[j].target;
      end
   end

endmodule

// File: tb/tb_cdb_broadcast.sv
// Scoreboard bench for cdb_broadcast: a queue-level model predicts readiness and every broadcast lane.
// Define CDB_BYPASS_EN consistently for RTL and bench to exercise the bypass build.
module tb_cdb_broadcast;
   import cdb_broadcast_pkg::*;

   localparam int unsigned NUM_FU    = 4;
   localparam int unsigned BUF_DEPTH = 8;

   typedef struct {
      cdb_packet_t pkt;
      int          lane;
      int          stamp;
   } sb_ent_t;

   logic              clock;
   logic              reset_n;
   logic              proc_nuke;
   logic [NUM_FU-1:0] fu_valid;
   logic [NUM_FU-1:0] fu_ready;
   logic [ROB_W-1:0]  fu_ROB_idx   [NUM_FU];
   logic [PRF_W-1:0]  fu_dest_PRN  [NUM_FU];
   logic [XLEN-1:0]   fu_value     [NUM_FU];
   logic [NUM_FU-1:0] fu_direction;
   logic [XLEN-1:0]   fu_target    [NUM_FU];
   logic [WAYS-1:0]   CDB_valid;
   logic [ROB_W-1:0]  CDB_ROB_idx  [WAYS];
   logic [PRF_W-1:0]  CDB_dest_PRN [WAYS];
   logic [XLEN-1:0]   CDB_value    [WAYS];
   logic [WAYS-1:0]   CDB_direction;
   logic [XLEN-1:0]   CDB_target   [WAYS];

   cdb_packet_t d_pkt [NUM_FU];
   cdb_packet_t mbuf [$];
   sb_ent_t     sb [$];
   cdb_packet_t mon_pkt;
   sb_ent_t     mon_ent;
   int          edge_no = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          seq = 0;

   cdb_broadcast #(.NUM_FU(NUM_FU), .BUF_DEPTH(BUF_DEPTH)) dut (
      .clock(clock), .reset_n(reset_n), .proc_nuke(proc_nuke),
      .fu_valid(fu_valid), .fu_ready(fu_ready),
      .fu_ROB_idx(fu_ROB_idx), .fu_dest_PRN(fu_dest_PRN), .fu_value(fu_value),
      .fu_direction(fu_direction), .fu_target(fu_target),
      .CDB_valid(CDB_valid), .CDB_ROB_idx(CDB_ROB_idx), .CDB_dest_PRN(CDB_dest_PRN),
      .CDB_value(CDB_value), .CDB_direction(CDB_direction), .CDB_target(CDB_target)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edge_no, act, exp);
      end
   endfunction

   // Fresh payloads; value carries a unique sequence number so loss/duplication is visible
   function automatic void new_pkts();
      for (int i = 0; i < int'(NUM_FU); i++) begin
         d_pkt[i].ROB_idx   = ROB_W'($urandom);
         d_pkt[i].dest_PRN  = PRF_W'($urandom);
         d_pkt[i].value     = XLEN'(seq);
         d_pkt[i].direction = 1'($urandom);
         d_pkt[i].target    = XLEN'($urandom);
         seq++;
      end
   endfunction

   // One clock of stimulus, starting between edges; the model advances right after the edge
   task automatic cycle(input logic [NUM_FU-1:0] v, input logic nuke);
      cdb_packet_t       acc_q [$];
      logic [NUM_FU-1:0] m_ready;
      sb_ent_t           ent;
      int                k;
      int                spare;
      int                nb;
      fu_valid  = v;
      proc_nuke = nuke;
      for (int i = 0; i < int'(NUM_FU); i++) begin
         fu_ROB_idx[i]   = d_pkt[i].ROB_idx;
         fu_dest_PRN[i]  = d_pkt[i].dest_PRN;
         fu_value[i]     = d_pkt[i].value;
         fu_direction[i] = d_pkt[i].direction;
         fu_target[i]    = d_pkt[i].target;
         m_ready[i]      = (int'(BUF_DEPTH) - mbuf.size()) > i;
      end
      chk("fu_ready", 128'(fu_ready), 128'(m_ready));
      for (int i = 0; i < int'(NUM_FU); i++) if (v[i] && m_ready[i]) acc_q.push_back(d_pkt[i]);
      @(posedge clock);
      edge_no++;
      if (!reset_n || nuke) begin
         mbuf.delete();
      end else begin
         k = (mbuf.size() < int'(WAYS)) ? mbuf.size() : int'(WAYS);
         for (int j = 0; j < k; j++) begin
            ent.pkt   = mbuf.pop_front();
            ent.lane  = j;
            ent.stamp = edge_no;
            sb.push_back(ent);
         end
`ifdef CDB_BYPASS_EN
         spare = int'(WAYS) - k;
`else
         spare = 0;
`endif
         nb = 0;
         foreach (acc_q[a]) begin
            if (nb < spare) begin
               ent.pkt   = acc_q[a];
               ent.lane  = k + nb;
               ent.stamp = edge_no;
               sb.push_back(ent);
               nb++;
            end else begin
               mbuf.push_back(acc_q[a]);
            end
         end
      end
      #1;
   endtask

   task automatic idle();
      new_pkts();
      cycle('0, 1'b0);
   endtask

   // Monitor: every valid lane must match the oldest expected result for this edge and lane
   always @(negedge clock) begin
      if (reset_n) begin
         for (int j = 0; j < int'(WAYS); j++) begin
            mon_pkt.ROB_idx   = CDB_ROB_idx[j];
            mon_pkt.dest_PRN  = CDB_dest_PRN[j];
            mon_pkt.value     = CDB_value[j];
            mon_pkt.direction = CDB_direction[j];
            mon_pkt.target    = CDB_target[j];
            if (CDB_valid[j]) begin
               if (sb.size() == 0) begin
                  chk("unexpected_valid", 128'(CDB_valid[j]), 128'(0));
               end else begin
                  mon_ent = sb.pop_front();
                  chk("cdb_payload", 128'(mon_pkt), 128'(mon_ent.pkt));
                  chk("cdb_lane", 128'(j), 128'(mon_ent.lane));
                  chk("cdb_edge", 128'(edge_no), 128'(mon_ent.stamp));
               end
            end else begin
               chk("idle_lane_zero", 128'(mon_pkt), 128'(0));
            end
         end
         while (sb.size() > 0 && sb[0].stamp <= edge_no) begin
            n_checks++;
            n_fail++;
            $display("FAIL missing_result at edge %0d: value 0x%0h never shown, expected lane %0d",
                     edge_no, sb[0].pkt.value, sb[0].lane);
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      reset_n   = 1'b0;
      proc_nuke = 1'b0;
      fu_valid  = '0;
      new_pkts();
      for (int i = 0; i < int'(NUM_FU); i++) begin
         fu_ROB_idx[i] = '0; fu_dest_PRN[i] = '0; fu_value[i] = '0; fu_target[i] = '0;
      end
      fu_direction = '0;
      #12;
      chk("in_reset_valid", 128'(CDB_valid), 128'(0));
      #10 reset_n = 1'b1;
      @(posedge clock);
      #1;
      chk("reset_valid", 128'(CDB_valid), 128'(0));
      chk("reset_ready", 128'(fu_ready), 128'(4'b1111));
      chk("reset_lane0", 128'(CDB_ROB_idx[0]), 128'(0));

      // Single result from FU1
      new_pkts();
      d_pkt[1].ROB_idx = ROB_W'(5);
      cycle(4'b0010, 1'b0);
`ifndef CDB_BYPASS_EN
      chk("single_early", 128'(CDB_valid), 128'(0));
      idle();
`endif
      chk("single_valid", 128'(CDB_valid), 128'(3'b001));
      chk("single_rob", 128'(CDB_ROB_idx[0]), 128'(5));
      repeat (3) idle();

      // All four FUs at once: three lanes, then the fourth alone
      new_pkts();
      for (int i = 0; i < int'(NUM_FU); i++) d_pkt[i].ROB_idx = ROB_W'(10 + i);
      cycle(4'b1111, 1'b0);
`ifndef CDB_BYPASS_EN
      idle();
`endif
      chk("quad_valid", 128'(CDB_valid), 128'(3'b111));
      chk("quad_rob0", 128'(CDB_ROB_idx[0]), 128'(10));
      chk("quad_rob1", 128'(CDB_ROB_idx[1]), 128'(11));
      chk("quad_rob2", 128'(CDB_ROB_idx[2]), 128'(12));
      idle();
      chk("quad_tail_valid", 128'(CDB_valid), 128'(3'b001));
      chk("quad_tail_rob", 128'(CDB_ROB_idx[0]), 128'(13));
      repeat (3) idle();

      // Saturating burst: occupancy settles at five, so only FU0-FU2 stay ready
      for (int c = 0; c < 30; c++) begin
         new_pkts();
         cycle(4'b1111, 1'b0);
      end
      chk("burst_ready", 128'(fu_ready), 128'(4'b0111));
      chk("burst_valid", 128'(CDB_valid), 128'(3'b111));

      // Flush with two transfers offered: nothing buffered or offered may ever appear
      new_pkts();
      cycle(4'b0011, 1'b1);
      chk("nuke_valid", 128'(CDB_valid), 128'(0));
      chk("nuke_ready", 128'(fu_ready), 128'(4'b1111));
      repeat (4) idle();

      // Randomized traffic with occasional flushes
      for (int c = 0; c < 300; c++) begin
         new_pkts();
         cycle(NUM_FU'($urandom), ($urandom_range(0, 39) == 0));
      end

      // Asynchronous reset in the middle of a full-lane burst
      for (int c = 0; c < 8; c++) begin
         new_pkts();
         cycle(4'b1111, 1'b0);
      end
      chk("pre_reset_valid", 128'(CDB_valid), 128'(3'b111));
      #1 reset_n = 1'b0;
      #1;
      chk("async_reset_valid", 128'(CDB_valid), 128'(0));
      chk("async_reset_payload", 128'(CDB_value[1]), 128'(0));
      chk("async_reset_ready", 128'(fu_ready), 128'(4'b1111));
      sb.delete();
      mbuf.delete();
      new_pkts();
      cycle(4'b1111, 1'b0);
      #1 reset_n = 1'b1;
      new_pkts();
      d_pkt[2].ROB_idx = ROB_W'(7);
      cycle(4'b0100, 1'b0);
`ifndef CDB_BYPASS_EN
      idle();
`endif
      chk("post_reset_valid", 128'(CDB_valid), 128'(3'b001));
      chk("post_reset_rob", 128'(CDB_ROB_idx[0]), 128'(7));

      for (int c = 0; c < 100; c++) begin
         new_pkts();
         cycle(NUM_FU'($urandom), 1'b0);
      end
      repeat (10) idle();
      chk("drain_model_buffer", 128'(mbuf.size()), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
